// File: rtl/icache_axi_refill.sv
// icache_axi_refill: single-outstanding AXI3 read master for instruction-cache
// line refills and uncached word fetches. Returned beats are collected into a
// line buffer that is handed back to the cache as one response.
module icache_axi_refill #(
    parameter int          LINE_WORDS = 8,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic                       aclk,
    input  logic                       reset,
    // cache request side
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [31:0]                req_addr,
    input  logic                       req_uncached,
    // cache response side
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [32*LINE_WORDS-1:0]   resp_line,
    output logic                       resp_err,
    // AXI read address channel
    output logic [3:0]                 arid,
    output logic [31:0]                araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic [1:0]                 arlock,
    output logic [3:0]                 arcache,
    output logic [2:0]                 arprot,
    output logic                       arvalid,
    input  logic                       arready,
    // AXI read data channel
    input  logic [3:0]                 rid,
    input  logic [31:0]                rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    input  logic                       rvalid,
    output logic                       rready
);

    localparam int CW   = $clog2(LINE_WORDS);
    localparam int OFFW = CW + 2;

    typedef enum logic [1:0] {IDLE, AR, R, RESP} state_e;

    state_e                          state_q, state_d;
    logic [31:0]                     araddr_q;
    logic [7:0]                      arlen_q;
    logic [CW-1:0]                   cnt_q;
    logic [LINE_WORDS-1:0][31:0]     line_q;
    logic                            err_q;
    // set once the expected final beat has been stored without rlast;
    // further beats up to rlast are dropped
    logic                            over_q;
    logic                            final_beat;

    // the interconnect routes by ID, so rid carries no information here
    logic                            rid_unused;
    assign rid_unused = ^rid;

    assign final_beat = ({{(8-CW){1'b0}}, cnt_q} == arlen_q);

    // state register
    always_ff @(posedge aclk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid)           state_d = AR;
            AR:   if (arready)             state_d = R;
            R:    if (rvalid && rlast)     state_d = RESP;
            RESP: if (resp_ready)          state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // output decode from state
    always_comb begin
        req_ready  = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE:    req_ready  = 1'b1;
            AR:      arvalid    = 1'b1;
            R:       rready     = 1'b1;
            RESP:    resp_valid = 1'b1;
            default: req_ready  = 1'b0;
        endcase
    end

    // request capture, beat collection and sticky error tracking
    always_ff @(posedge aclk) begin
        if (reset) begin
            araddr_q <= '0;
            arlen_q  <= '0;
            cnt_q    <= '0;
            line_q   <= '0;
            err_q    <= 1'b0;
            over_q   <= 1'b0;
        end else if (state_q == IDLE && req_valid) begin
            if (req_uncached) begin
                araddr_q <= {req_addr[31:2], 2'b00};
                arlen_q  <= 8'd0;
            end else begin
                araddr_q <= {req_addr[31:OFFW], {OFFW{1'b0}}};
                arlen_q  <= 8'(LINE_WORDS - 1);
            end
            cnt_q  <= '0;
            line_q <= '0;
            err_q  <= 1'b0;
            over_q <= 1'b0;
        end else if (state_q == R && rvalid) begin
            if (rresp != 2'b00) err_q <= 1'b1;
            if (!over_q) begin
                line_q[cnt_q] <= rdata;
                if (final_beat) begin
                    // burst longer than requested: hold here until rlast
                    if (!rlast) begin
                        err_q  <= 1'b1;
                        over_q <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    if (rlast) err_q <= 1'b1;
                end
            end
        end
    end

    assign araddr    = araddr_q;
    assign arlen     = arlen_q;
    assign arid      = AXI_ID;
    assign arsize    = 3'b010;
    assign arburst   = 2'b01;
    assign arlock    = 2'b00;
    assign arcache   = 4'b0000;
    assign arprot    = 3'b000;
    assign resp_line = line_q;
    assign resp_err  = err_q;

endmodule

// File: tb/tb_icache_axi_refill.sv
// Randomized bench for icache_axi_refill with a transaction-level reference.
module tb_icache_axi_refill;

    localparam int LW = 8;
    localparam int W  = 32 * LW;

    logic          aclk, reset;
    logic          req_valid, req_ready, req_uncached;
    logic [31:0]   req_addr;
    logic          resp_valid, resp_ready, resp_err;
    logic [W-1:0]  resp_line;
    logic [3:0]    arid;
    logic [31:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst, arlock;
    logic [3:0]    arcache;
    logic [2:0]    arprot;
    logic          arvalid, arready;
    logic [3:0]    rid;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready;

    icache_axi_refill #(.LINE_WORDS(LW), .AXI_ID(4'd0)) dut (
        .aclk(aclk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_uncached(req_uncached),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_line(resp_line),
        .resp_err(resp_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // beats the slave will return for the next transaction
    logic [31:0] bd[64];
    logic [1:0]  br[64];

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) begin
            bd[i] = $urandom;
            br[i] = 2'b00;
        end
    endtask

    // One full transaction. gap: 0 none, 1 alternate, 2 random rvalid.
    // rst_at >= 0 asserts reset after that many beats instead of finishing.
    task automatic run_txn(input logic [31:0] addr, input logic unc, input int ar_dly,
                           input int nb, input int gap, input int rr_dly, input int rst_at);
        logic [31:0]  ea;
        logic [7:0]   el;
        logic [W-1:0] eline;
        logic         eerr, rv;
        int           L, cyc, k, guard;

        // reference: what the cache should see for this burst
        L     = unc ? 1 : LW;
        ea    = unc ? (addr & ~32'h3) : (addr & ~32'(LW * 4 - 1));
        el    = 8'(L - 1);
        eline = '0;
        eerr  = (nb != L);
        for (int i = 0; i < nb; i++) begin
            if (br[i] != 2'b00) eerr = 1'b1;
            if (i < L) eline[32*i +: 32] = bd[i];
        end

        req_valid    = 1'b1;
        req_addr     = addr;
        req_uncached = unc;
        @(negedge aclk);
        chk("req_ready_idle", req_ready, 1'b1);
        @(posedge aclk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        cyc = 1;

        for (int i = 0; i <= ar_dly; i++) begin
            arready = (i == ar_dly);
            @(negedge aclk);
            chk("arvalid", arvalid, 1'b1);
            chk("araddr", araddr, ea);
            chk("arlen", arlen, el);
            chk("arburst", arburst, 2'b01);
            @(posedge aclk); #1;
            cyc++;
        end
        arready = 1'b0;

        k = 0;
        guard = 0;
        while (k < nb && k != rst_at && guard < 500) begin
            rv = (gap == 0) ? 1'b1 : (gap == 1) ? (guard % 2 == 0) : 1'($urandom % 2);
            rvalid = rv;
            rdata  = rv ? bd[k] : $urandom;
            rresp  = rv ? br[k] : 2'($urandom);
            rlast  = rv ? (k == nb - 1) : 1'($urandom);
            @(negedge aclk);
            chk("rready", rready, 1'b1);
            @(posedge aclk); #1;
            cyc++;
            guard++;
            if (rv) k++;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        if (guard >= 500) chk("beat_timeout", 1'b0, 1'b1);

        if (rst_at >= 0) begin
            reset = 1'b1;
            @(posedge aclk); #1;
            reset = 1'b0;
            @(negedge aclk);
            chk("rst_req_ready", req_ready, 1'b1);
            chk("rst_rready", rready, 1'b0);
            chk("rst_resp_valid", resp_valid, 1'b0);
            chk("rst_arvalid", arvalid, 1'b0);
            @(posedge aclk); #1;
            return;
        end

        for (int i = 0; i <= rr_dly; i++) begin
            resp_ready = (i == rr_dly);
            @(negedge aclk);
            chk("resp_valid", resp_valid, 1'b1);
            chk("req_ready_busy", req_ready, 1'b0);
            chk("resp_line", resp_line, eline);
            chk("resp_err", resp_err, eerr);
            if (i == 0 && gap == 0) chk("latency", cyc, ar_dly + nb + 2);
            @(posedge aclk); #1;
        end
        resp_ready = 1'b0;
        @(negedge aclk);
        chk("resp_valid_drop", resp_valid, 1'b0);
        chk("req_ready_back", req_ready, 1'b1);
        @(posedge aclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int L, nb;
        logic unc;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_uncached = 1'b0;
        resp_ready = 1'b0; arready = 1'b0; rid = 4'd0; rdata = '0; rresp = '0;
        rlast = 1'b0; rvalid = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_arlen", arlen, 8'h0);
        chk("rst_line", resp_line, '0);
        chk("rst_arsize", arsize, 3'b010);
        chk("rst_arburst", arburst, 2'b01);
        chk("rst_const", {arid, arlock, arcache, arprot}, 13'h0);
        @(posedge aclk); #1;
        reset = 1'b0;

        // cached refill, back-to-back beats
        fill_rand();
        for (int i = 0; i < LW; i++) bd[i] = 32'hA0 + 32'(i);
        run_txn(32'h1FC0_0014, 1'b0, 0, LW, 0, 0, -1);
        // uncached word with stalled arready
        fill_rand();
        bd[0] = 32'hDEAD_BEEF;
        run_txn(32'hBFC0_0006, 1'b1, 3, 1, 0, 0, -1);
        // rvalid gaps and withheld resp_ready
        fill_rand();
        run_txn($urandom, 1'b0, 0, LW, 1, 4, -1);
        // error response on beat 3
        fill_rand();
        br[2] = 2'b10;
        run_txn($urandom, 1'b0, 0, LW, 0, 0, -1);
        // early rlast on beat 5
        fill_rand();
        run_txn($urandom, 1'b0, 0, 5, 0, 0, -1);
        // missing rlast on final beat, burst runs long
        fill_rand();
        run_txn($urandom, 1'b0, 1, LW + 2, 0, 1, -1);
        // uncached burst with an extra beat
        fill_rand();
        run_txn($urandom, 1'b1, 0, 2, 0, 0, -1);
        // reset mid-burst after beat 4, then a clean transaction
        fill_rand();
        run_txn($urandom, 1'b0, 0, LW, 0, 0, 4);
        fill_rand();
        run_txn($urandom, 1'b0, 0, LW, 0, 0, -1);

        for (int t = 0; t < 30; t++) begin
            fill_rand();
            unc = ($urandom % 4 == 0);
            L   = unc ? 1 : LW;
            nb  = ($urandom % 8 == 0) ? int'($urandom_range(1, L + 3)) : L;
            for (int i = 0; i < nb; i++)
                if ($urandom % 16 == 0) br[i] = 2'($urandom_range(1, 3));
            run_txn($urandom, unc, int'($urandom % 4), nb, int'($urandom % 3),
                    int'($urandom % 4), -1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
